// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Segment codes are active-low, bit order g..a.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Shift-add-3 correction applied to every nibble before each shift.
  function automatic logic [19:0] bcd_adj3(input logic [19:0] bcd);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one bit per cycle.
// busy spans capture through commit (17 cycles); o_commit marks the cycle the result is final.
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_commit,
  output logic [19:0] o_bcd
);

  conv_state_e r_state;
  conv_state_e w_state_nxt;
  logic [15:0] r_bin;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [35:0] w_shift;

  assign w_shift = {bcd_adj3(r_bcd), r_bin} << 1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_load) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == 4'd15) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == COMMIT);
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_bin <= i_value;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_bcd <= w_shift[35:16];
          r_bin <= w_shift[15:0];
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_commit = (r_state == COMMIT);
  assign o_done   = r_done;
  assign o_bcd    = r_bcd;

endmodule

// File: rtl/disp_ctrl.sv
// Multiplexed seven-segment display controller: sequential BCD conversion plus
// a registered anode/segment scanner with optional leading-zero blanking.
module disp_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 5,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [6:0]  sseg,
  output logic [7:0]  an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          w_commit;
  logic [19:0]   w_bcd;
  logic [19:0]   r_digits;
  logic [19:0]   w_digits_nxt;
  logic [31:0]   w_digits_ext;
  logic [CW-1:0] r_scan_cnt;
  logic          w_wrap;
  logic [2:0]    r_slot;
  logic [2:0]    w_slot_nxt;
  logic [2:0]    w_hi_idx;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [7:0]    w_an;
  logic [6:0]    w_sseg;
  logic [7:0]    r_an;
  logic [6:0]    r_sseg;

  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst      (rst),
    .i_value  (value),
    .i_load   (load),
    .o_busy   (busy),
    .o_done   (done),
    .o_commit (w_commit),
    .o_bcd    (w_bcd)
  );

  // Decode from the post-commit digits so a commit on a wrap edge shows immediately.
  assign w_digits_nxt = w_commit ? w_bcd : r_digits;
  assign w_digits_ext = {12'h000, w_digits_nxt};

  assign w_wrap     = (r_scan_cnt == CW'(SCAN_DIV - 1));
  assign w_slot_nxt = (r_slot == 3'(DIGITS - 1)) ? 3'd0 : r_slot + 3'd1;

  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < 5; i++) begin
      if (w_digits_nxt[i*4 +: 4] != 4'd0) w_hi_idx = 3'(i);
    end
  end

  assign w_digit = w_digits_ext[{r_slot, 2'b00} +: 4];
  assign w_blank = (LZ_BLANK != 0) && (r_slot > w_hi_idx);
  assign w_an    = w_blank ? AN_OFF : ~(8'd1 << r_slot);
  assign w_sseg  = w_blank ? SEG_BLANK : seg_decode(w_digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits   <= '0;
      r_scan_cnt <= '0;
      r_slot     <= '0;
      r_an       <= AN_OFF;
      r_sseg     <= SEG_BLANK;
    end else begin
      r_digits   <= w_digits_nxt;
      r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + CW'(1);
      if (w_wrap) begin
        r_an   <= w_an;
        r_sseg <= w_sseg;
        r_slot <= w_slot_nxt;
      end
    end
  end

  assign an   = r_an;
  assign sseg = r_sseg;

endmodule

// File: doc/disp_ctrl.md
# disp_ctrl

Sequencing controller for the board's 8-digit multiplexed seven-segment display. It accepts a 16-bit unsigned value through a load handshake and converts it to five BCD digits with a sequential shift-add-3 engine, one bit per cycle. It then time-multiplexes those digits onto the shared segment/anode bus at a programmable refresh rate. It sits between the ALU result path and the display pins and replaces any combinational divide/modulo conversion.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- DIGITS, 5: number of scanned digit positions; legal range 1..8.
- LZ_BLANK, 1: 1 blanks leading zeros; 0 shows all DIGITS positions.
- clk  in  1  system clock. One clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- value  in  16  unsigned binary value to display.
- load  in  1  request to convert `value`; sampled only in IDLE.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits become visible.
- sseg  out  7  segments g..a, active-low; 7'h7F means blank.
- an  out  8  anodes, active-low one-hot; 8'hFF means all off.

## Operation
- Conversion FSM has three states:
  - IDLE: if `load`=1, capture `value` into the shift register, clear the 20-bit BCD accumulator and bit counter, then go to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1. After 16 shifts, go to COMMIT.
  - COMMIT: copy the accumulator into the 5×4-bit display digit register, pulse `done`, and return to IDLE.
- `load` outside IDLE is ignored; it is not queued.
- A `load` held high is re-accepted on the first IDLE cycle after COMMIT.
- The display digit register changes only in COMMIT. Scanning always shows a complete old or complete new number, never a partial conversion.
- The maximum value 65535 needs 5 digits. Digit i is BCD position i (0 = units).
- Scan scheduler:
  - A free-running counter counts 0..SCAN_DIV-1. On wrap, the slot index advances 0→1→…→DIGITS-1→0.
  - For slot i, `an[i]`=0 and all other bits are 1. `an[7:DIGITS]` is always 1.
  - `sseg` is the decode of digit i.
- Leading-zero blanking applies when LZ_BLANK=1. Slot i is blanked when i > index of the highest nonzero digit. Slot 0 is never blanked.
- A blanked slot drives `an`=8'hFF and `sseg`=7'h7F. The slot still consumes its time.
- Decode covers 0–9 only. Codes 10–15 cannot occur; decode them to blank.

## Timing
- Reset values: `an`=8'hFF, `sseg`=7'h7F, `busy`=0, `done`=0.
- Reset also clears the digit register, slot index and scan counter, and puts the FSM in IDLE.
- Reset mid-conversion aborts the conversion. The display returns to "0", and no `done` pulse is produced.
- Conversion latency:
  - `load` is sampled at edge k.
  - `busy`=1 from edge k through edge k+17, i.e. 17 cycles.
  - SHIFT occupies edges k+1..k+16.
  - COMMIT completes at edge k+17. `done`=1 for exactly the cycle after edge k+17, and `busy` falls at the same edge.
  - New digits drive `sseg` in the next scan slot whose index matches.
- `an` and `sseg` are registered and update together on the scan-wrap edge. There is no cycle where the anode and segments disagree.
- First visible output after reset: at edge SCAN_DIV, slot 0 shows "0".
- Scan and conversion are independent. A COMMIT coinciding with a scan wrap shows the new digit in the slot being entered.

## Structure
- Package `disp_pkg` contains:
  - the FSM state enum {IDLE, SHIFT, COMMIT};
  - the segment constants SEG_BLANK=7'h7F and AN_OFF=8'hFF;
  - the 0–9 segment lookup.
- Sub-module `bin2bcd_seq` contains the conversion FSM, the accumulator and the busy/done logic.
- The top level holds the digit register, the scan counter, the blanking logic and the decode.

## Test plan
- Reset, then `value`=65535, `load` for 1 cycle. Required: `busy` high exactly 17 cycles, then `done` pulse. Digits 5,3,5,5,6 (units first). With SCAN_DIV=4, `an` cycles FE,FD,FB,F7,EF with `sseg` showing 5,3,5,5,6.
- `value`=100 with LZ_BLANK=1. Required: digits 0,0,1,0,0. Slots 3 and 4 drive `an`=FF and `sseg`=7F. Slots 0–2 show 0,0,1.
- `value`=0. Required: only slot 0 is lit, showing "0". Repeat with LZ_BLANK=0: all 5 slots show "0".
- Load 1234, then assert `load` with `value`=9999 at cycle 5 of busy. Required: second request ignored, display shows 1234, exactly one `done` pulse.
- Assert `rst` at SHIFT cycle 8 of a 4321 conversion. Required: next cycle `busy`=0 and `an`=FF. No `done` pulse. After SCAN_DIV cycles, slot 0 shows "0".
- Hold `load`=1 continuously with `value`=7. Required: back-to-back conversions with one IDLE cycle between them. `done` pulses every 18 cycles.
